// File: rtl/vec_mul_seq_if.sv
// Handshake and operand/result bus for vec_mul_seq.
// Defining MUL_SAT_EN adds the sat_mode signal.
interface vec_mul_seq_if #(
    parameter int N     = 18,
    parameter int LANES = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*N-1:0]   a;
    logic [LANES*N-1:0]   b;
`ifdef MUL_SAT_EN
    logic                 sat_mode;
`endif
    logic                 abort;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*N-1:0]   result;
    logic [LANES-1:0]     overflow;
    logic                 car;

    modport master (
`ifdef MUL_SAT_EN
        output sat_mode,
`endif
        output in_valid, a, b, abort, out_ready,
        input  in_ready, out_valid, result, overflow, car
    );

    modport slave (
`ifdef MUL_SAT_EN
        input  sat_mode,
`endif
        input  in_valid, a, b, abort, out_ready,
        output in_ready, out_valid, result, overflow, car
    );
endinterface

// File: rtl/vec_mul_seq.sv
// Multi-lane signed sequential multiplier, one multiplier bit per lane per cycle.
// Defining MUL_SAT_EN enables per-operation saturation selected by sat_mode.
module vec_mul_seq #(
    parameter int N     = 18,
    parameter int LANES = 4
) (
    input logic          clk,
    input logic          rst_n,
    vec_mul_seq_if.slave bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic signed [2*N-1:0] acc    [LANES];
    logic signed [2*N-1:0] mcand  [LANES];
    logic [N-1:0]          mplier [LANES];
    logic signed [2*N-1:0] step   [LANES];
    logic [LANES*N-1:0]    result_q;
    logic [LANES*N-1:0]    res_c;
    logic [LANES-1:0]      ovf_q;
    logic [LANES-1:0]      ovf_c;
`ifdef MUL_SAT_EN
    logic                  sat_q;
`endif

    // The multiplier's top bit carries negative weight, so the final step subtracts.
    always_comb begin
        step  = acc;
        res_c = '0;
        ovf_c = '0;
        for (int i = 0; i < LANES; i++) begin
            if (mplier[i][0])
                step[i] = (count == '0) ? acc[i] - mcand[i] : acc[i] + mcand[i];
            ovf_c[i] = (step[i][2*N-1:N-1] != '0) && (step[i][2*N-1:N-1] != '1);
            res_c[i*N +: N] = step[i][N-1:0];
`ifdef MUL_SAT_EN
            if (sat_q && ovf_c[i])
                res_c[i*N +: N] = step[i][2*N-1] ? {1'b1, {(N-1){1'b0}}}
                                                 : {1'b0, {(N-1){1'b1}}};
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            result_q <= '0;
            ovf_q    <= '0;
`ifdef MUL_SAT_EN
            sat_q    <= 1'b0;
`endif
            for (int i = 0; i < LANES; i++) begin
                acc[i]    <= '0;
                mcand[i]  <= '0;
                mplier[i] <= '0;
            end
        end else if (bus.abort) begin
            state    <= IDLE;
            count    <= '0;
            result_q <= '0;
            ovf_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < LANES; i++) begin
                            acc[i]    <= '0;
                            mcand[i]  <= {{N{bus.a[i*N+N-1]}}, bus.a[i*N +: N]};
                            mplier[i] <= bus.b[i*N +: N];
                        end
`ifdef MUL_SAT_EN
                        sat_q <= bus.sat_mode;
`endif
                        count <= CW'(N-1);
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    for (int i = 0; i < LANES; i++) begin
                        acc[i]    <= step[i];
                        mcand[i]  <= mcand[i] <<< 1;
                        mplier[i] <= mplier[i] >> 1;
                    end
                    if (count == '0) begin
                        result_q <= res_c;
                        ovf_q    <= ovf_c;
                        state    <= DONE;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        result_q <= '0;
                        ovf_q    <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.overflow  = ovf_q;
    assign bus.car       = 1'b0;
endmodule

// File: tb/tb_vec_mul_seq.sv
// Self-checking bench for vec_mul_seq against an arithmetic reference model.
// Saturation cases are exercised only when MUL_SAT_EN is defined.
module tb_vec_mul_seq;
    localparam int N     = 18;
    localparam int LANES = 4;
    localparam int W     = N * LANES;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    vec_mul_seq_if #(.N(N), .LANES(LANES)) bus ();

    vec_mul_seq #(.N(N), .LANES(LANES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rnd_vec();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
        logic [W-1:0] v;
        v = '0;
        v[0*N +: N] = l0[N-1:0];
        v[1*N +: N] = l1[N-1:0];
        v[2*N +: N] = l2[N-1:0];
        v[3*N +: N] = l3[N-1:0];
        return v;
    endfunction

    // Exact signed product per lane, then range check and wrap/clamp.
    task automatic modelCalc(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sm,
                             output logic [W-1:0] r, output logic [LANES-1:0] o);
        logic signed [N-1:0] la;
        logic signed [N-1:0] lb;
        longint p;
        longint rl;
        longint maxv;
        longint minv;
        maxv = (longint'(1) <<< (N-1)) - 1;
        minv = -(longint'(1) <<< (N-1));
        r = '0;
        o = '0;
        for (int i = 0; i < LANES; i++) begin
            la = av[i*N +: N];
            lb = bv[i*N +: N];
            p  = longint'(la) * longint'(lb);
            o[i] = (p > maxv) || (p < minv);
            rl = p;
            if (sm && o[i])
                rl = (p > 0) ? maxv : minv;
            r[i*N +: N] = rl[N-1:0];
        end
    endtask

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_sat(input logic s);
`ifdef MUL_SAT_EN
        bus.sat_mode = s;
`else
        if (s) $display("[TB] sat_mode requested but not built in");
`endif
    endtask

    // Offers one operand set; returns #1 after the accept edge with junk on the inputs.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sm);
        @(negedge clk);
        bus.a        = av;
        bus.b        = bv;
        set_sat(sm);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = rnd_vec();
        bus.b        = rnd_vec();
        set_sat(1'b0);
    endtask

    task automatic watch_no_valid(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        checkOutput(tag, W'(seen), '0);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sm, input int stall);
        logic [W-1:0]     er;
        logic [LANES-1:0] eo;
        int               cnt;
        modelCalc(av, bv, sm, er, eo);
        applyStimulus(av, bv, sm);
        checkOutput({tag, "_busy_ready"}, W'(bus.in_ready), '0);
        cnt = 0;
        while (!bus.out_valid && cnt < N + 10) begin
            @(posedge clk);
            #1;
            cnt++;
            if (!bus.out_valid && bus.result != '0)
                checkOutput({tag, "_busy_result"}, bus.result, '0);
        end
        checkOutput({tag, "_latency"}, W'(cnt), W'(N));
        checkOutput({tag, "_result"}, bus.result, er);
        checkOutput({tag, "_overflow"}, W'(bus.overflow), W'(eo));
        repeat (stall) begin
            @(posedge clk);
            #1;
            checkOutput({tag, "_hold_result"}, bus.result, er);
            checkOutput({tag, "_hold_valid"}, W'({bus.out_valid, bus.in_ready, bus.overflow}),
                        W'({1'b1, 1'b0, eo}));
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput({tag, "_release"}, W'({bus.out_valid, bus.in_ready}), W'(2'b01));
        checkOutput({tag, "_cleared"}, bus.result, '0);
    endtask

    initial begin
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic         sm;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        set_sat(1'b0);

        #2;
        checkOutput("reset_flags", W'({bus.in_ready, bus.out_valid, bus.car}), W'(3'b100));
        checkOutput("reset_result", bus.result, '0);
        checkOutput("reset_overflow", W'(bus.overflow), '0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("small", pack4(3, 3, 3, 3), pack4(-5, -5, -5, -5), 1'b0, 0);
        run_op("minmin_wrap", pack4(-131072, -131072, -131072, -131072),
               pack4(-131072, -131072, -131072, -131072), 1'b0, 0);
        run_op("mixed_wrap", pack4(1000, -1000, 2, 0), pack4(1000, 1000, 3, -7), 1'b0, 0);
`ifdef MUL_SAT_EN
        run_op("minmin_sat", pack4(-131072, -131072, -131072, -131072),
               pack4(-131072, -131072, -131072, -131072), 1'b1, 0);
        run_op("mixed_sat", pack4(1000, -1000, 2, 0), pack4(1000, 1000, 3, -7), 1'b1, 1);
`endif
        run_op("stall5", pack4(-77, 123, 131071, -1), pack4(45, -9, 1, -131072), 1'b0, 5);

        $display("[TB] reset during busy");
        applyStimulus(pack4(7, 7, 7, 7), pack4(9, 9, 9, 9), 1'b0);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_flags", W'({bus.in_ready, bus.out_valid}), W'(2'b10));
        checkOutput("midreset_result", bus.result, '0);
        checkOutput("midreset_overflow", W'(bus.overflow), '0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_valid("midreset_novalid", N + 5);

        $display("[TB] abort during busy");
        applyStimulus(pack4(5, 6, 7, 8), pack4(1, 2, 3, 4), 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        checkOutput("abort_busy_ready", W'(bus.in_ready), W'(1));
        watch_no_valid("abort_busy_novalid", N + 5);

        $display("[TB] abort with in_valid in idle");
        @(negedge clk);
        bus.a        = pack4(11, 12, 13, 14);
        bus.b        = pack4(2, 2, 2, 2);
        bus.in_valid = 1'b1;
        bus.abort    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.abort    = 1'b0;
        checkOutput("abort_idle_ready", W'(bus.in_ready), W'(1));
        watch_no_valid("abort_idle_novalid", N + 3);

        $display("[TB] abort while done");
        applyStimulus(pack4(100, 200, 300, 400), pack4(3, 3, 3, 3), 1'b0);
        repeat (N) @(posedge clk);
        #1;
        checkOutput("abort_done_valid", W'(bus.out_valid), W'(1));
        @(negedge clk);
        bus.abort     = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        checkOutput("abort_done_flags", W'({bus.in_ready, bus.out_valid}), W'(2'b10));
        checkOutput("abort_done_result", bus.result, '0);

        for (int k = 0; k < 8; k++) begin
            av = rnd_vec();
            bv = rnd_vec();
            if (k % 2 == 1) bv[N +: N] = av[N +: N] >> 9;
`ifdef MUL_SAT_EN
            sm = 1'($urandom_range(0, 1));
`else
            sm = 1'b0;
`endif
            run_op("random", av, bv, sm, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
